// File: rtl/seed_fetch.sv
// Initiator for the randombytes generator: pulses start, waits for done (with timeout),
// latches the seed and streams it LSW-first as WORD_W-bit words over valid/ready.
module seed_fetch #(
  parameter int unsigned IN_LEN  = 32,
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  output logic                rng_start,
  input  logic                rng_done,
  input  logic [IN_LEN*8-1:0] rng_zeta,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                err
);

  localparam int unsigned SeedW  = IN_LEN * 8;
  localparam int unsigned NWords = SeedW / WORD_W;
  localparam int unsigned IdxW   = (NWords > 1) ? $clog2(NWords) : 1;
  localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NWords - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StStream, StErr} state_e;

  state_e            state_q, state_d;
  logic [SeedW-1:0]  seed_q, seed_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_d, valid_d, last_d, busy_d, err_d;
  logic [WORD_W-1:0] data_d;

  // Output registers are loaded with next-cycle values so every output is a flop.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    valid_d = out_valid;
    last_d  = out_last;
    data_d  = out_data;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StStart;
          start_d = 1'b1;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done on the final allowed cycle takes priority over the timeout.
        if (rng_done) begin
          seed_d  = rng_zeta;
          idx_d   = '0;
          state_d = StStream;
          valid_d = 1'b1;
          data_d  = rng_zeta[WORD_W-1:0];
          last_d  = (NWords == 1);
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStream: begin
        if (out_valid && out_ready) begin
          if (idx_q == IdxLast) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StIdle;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = seed_q[idx_d*WORD_W +: WORD_W];
            last_d = (idx_d == IdxLast);
          end
        end
      end
      StErr: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      seed_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rng_start <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rng_start <= start_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_seed_fetch.sv
// Directed bench for seed_fetch: a cycle table for the basic fetch plus hand-written
// sequences for backpressure, timeout, boundary done, ignored inputs and async reset.
module tb_seed_fetch;

  logic         clk, rst, req, rng_start, rng_done, out_valid, out_ready, out_last, busy, err;
  logic [255:0] rng_zeta;
  logic [63:0]  out_data;

  int n_vec  = 0;
  int n_fail = 0;

  seed_fetch #(
    .IN_LEN (32),
    .WORD_W (64),
    .TIMEOUT(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rng_start(rng_start),
    .rng_done (rng_done),
    .rng_zeta (rng_zeta),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req, done, ready;
    logic        start, valid, last, busy, err;
    logic        chk_data;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Pulse req, keep done low for dly cycles after START, then raise done for one cycle.
  task automatic fetch(input logic [255:0] z, input int dly, input string tag);
    int bad;
    bad      = 0;
    rng_zeta = z;
    req      = 1'b1;
    tick();
    check({tag, " start"}, {63'd0, rng_start}, 64'd1);
    req = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (rng_start || out_valid || err || !busy) bad++;
    end
    rng_done = 1'b1;
    tick();
    rng_done = 1'b0;
    check({tag, " wait quiet"}, 64'(bad), 64'd0);
    check({tag, " first valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  // Consume the stream with ready taken from pat (bit per cycle, 1 beyond bit 31).
  task automatic drain(input logic [255:0] z, input logic [31:0] pat, input bit poke_req,
                       input string tag);
    int          acc, bad;
    bit          holding;
    logic [63:0] held, words[4];
    logic        held_last, lasts[4];
    acc     = 0;
    bad     = 0;
    holding = 0;
    held    = '0;
    held_last = 1'b0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      out_ready = (c < 32) ? pat[c] : 1'b1;
      req       = poke_req && (c == 1);
      if (rng_start) bad++;
      if (holding && (!out_valid || out_data !== held || out_last !== held_last)) bad++;
      holding = 0;
      if (out_valid) begin
        if (out_ready) begin
          words[acc] = out_data;
          lasts[acc] = out_last;
          acc++;
        end else begin
          holding   = 1;
          held      = out_data;
          held_last = out_last;
        end
      end
      tick();
    end
    req       = 1'b0;
    out_ready = 1'b0;
    check({tag, " handshakes"}, 64'(acc), 64'd4);
    for (int k = 0; k < acc; k++) begin
      check($sformatf("%s word%0d", tag, k), words[k], z[k*64 +: 64]);
      check($sformatf("%s last%0d", tag, k), {63'd0, lasts[k]}, {63'd0, (k == 3)});
    end
    check({tag, " stable/no start"}, 64'(bad), 64'd0);
    check({tag, " idle after"}, {62'd0, busy, out_valid}, 64'd0);
  endtask

  logic [255:0] z1, z2;

  initial begin
    for (int i = 0; i < 32; i++) begin
      z1[i*8 +: 8] = 8'(i);
      z2[i*8 +: 8] = 8'(8'hFF - i);
    end
    rst       = 1'b1;
    req       = 1'b0;
    rng_done  = 1'b0;
    out_ready = 1'b0;
    rng_zeta  = z1;
    #2;
    check("reset ctl", {59'd0, rng_start, out_valid, out_last, busy, err}, 64'd0);
    check("reset data", out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // req, done, ready | start, valid, last, busy, err | chk_data, data
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0706050403020100};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0F0E0D0C0B0A0908};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1716151413121110};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1F1E1D1C1B1A1918};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};

    for (int i = 0; i < 11; i++) begin
      req       = vecs[i].req;
      rng_done  = vecs[i].done;
      out_ready = vecs[i].ready;
      tick();
      n_vec++;
      if ({rng_start, out_valid, out_last, busy, err} !==
          {vecs[i].start, vecs[i].valid, vecs[i].last, vecs[i].busy, vecs[i].err} ||
          (vecs[i].chk_data && out_data !== vecs[i].data)) begin
        n_fail++;
        $display("FAIL vec%0d: got start/valid/last/busy/err=%b data=%h, expected %b data=%h",
                 i, {rng_start, out_valid, out_last, busy, err}, out_data,
                 {vecs[i].start, vecs[i].valid, vecs[i].last, vecs[i].busy, vecs[i].err},
                 vecs[i].data);
      end
    end
    rng_done  = 1'b0;
    out_ready = 1'b0;
    tick();

    // Backpressure: word1 stalled 3 cycles, then ready on alternate cycles.
    fetch(z1, 5, "bp");
    drain(z1, 32'hFFFF_FF51, 1'b0, "bp");

    // Timeout: START, then WAIT cycles 0..99, then ERR.
    begin
      int n, bad;
      n   = 0;
      bad = 0;
      req = 1'b1;
      tick();
      req = 1'b0;
      while (!err && n < 200) begin
        tick();
        n++;
        if (out_valid) bad++;
      end
      check("timeout cycles", 64'(n), 64'd101);
      check("timeout valid", 64'(bad), 64'd0);
      tick();
      check("err pulse/idle", {62'd0, err, busy}, 64'd0);
    end
    fetch(z2, 3, "post-to");
    drain(z2, 32'hFFFF_FFFF, 1'b0, "post-to");

    // Done on the last allowed WAIT cycle.
    fetch(z1, 100, "bnd");
    drain(z1, 32'hFFFF_FFFF, 1'b0, "bnd");

    // req during STREAM, then rng_done while IDLE.
    fetch(z2, 3, "ign");
    drain(z2, 32'hFFFF_FFFF, 1'b1, "ign");
    begin
      int bad;
      bad      = 0;
      rng_done = 1'b1;
      repeat (3) begin
        tick();
        if (busy || rng_start || out_valid) bad++;
      end
      rng_done = 1'b0;
      check("idle done ignored", 64'(bad), 64'd0);
    end

    // Async reset after word 1 is accepted.
    fetch(z1, 2, "rst");
    out_ready = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    req       = 1'b0;
    out_ready = 1'b0;
    #1;
    check("async rst ctl", {59'd0, rng_start, out_valid, out_last, busy, err}, 64'd0);
    check("async rst data", out_data, 64'd0);
    #2 rst = 1'b0;
    tick();
    check("post rst idle", {62'd0, busy, rng_start}, 64'd0);
    fetch(z2, 2, "post-rst");
    drain(z2, 32'hFFFF_FFFF, 1'b0, "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seed_fetch.md
Name: seed_fetch

Overview:
Initiator-side controller for the randombytes generator. On a request it issues a one-cycle start pulse and waits for the generator's done flag, with a timeout. It then latches the IN_LEN-byte seed (zeta) and streams it to a downstream consumer, such as the SHAKE absorb stage of keygen, as WORD_W-bit words over a valid/ready handshake. It is the consumer end of the start/random_done/zeta_out interface.

Parameters:
IN_LEN, 32, seed length in bytes; must match randombytes IN_LEN.
WORD_W, 64, output word width in bits; IN_LEN*8 must be an integer multiple of WORD_W.
TIMEOUT, 100, maximum number of WAIT cycles before an error is flagged; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
req  input  1  request a new seed; sampled only in IDLE.
rng_start  output  1  one-cycle start pulse to randombytes.
rng_done  input  1  randombytes done flag; level or pulse, sampled only in WAIT.
rng_zeta  input  IN_LEN*8  randombytes zeta_out; sampled in the cycle rng_done is seen.
out_data  output  WORD_W  current seed word.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
out_last  output  1  high with the final word of the seed.
busy  output  1  high in every state except IDLE.
err  output  1  one-cycle pulse on timeout.

Behaviour:
- One clock; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: rng_start=0, out_data=0, out_valid=0, out_last=0, busy=0, err=0. The seed register, word index and timeout counter all reset to 0. State resets to IDLE.
- NWORDS = IN_LEN*8/WORD_W (default 4). Index width is clog2(NWORDS), minimum 1.
- States: IDLE, START, WAIT, STREAM, ERR.
- IDLE:
  - If req=1 at a posedge, go to START. rng_start=1 and busy=1 in the following cycle.
  - If req=0, stay. rng_done is ignored in IDLE.
- START: lasts exactly one cycle (the rng_start pulse). Clear the timeout counter, then go to WAIT. rng_start=0 from WAIT onward.
- WAIT:
  - rng_done=1: capture rng_zeta into the seed register, set index=0, go to STREAM. out_valid=1 with word 0 in the next cycle.
  - rng_done=0: increment the counter. When the counter reaches TIMEOUT-1 with rng_done still 0, go to ERR.
  - rng_done is therefore accepted on WAIT cycles 0..TIMEOUT-1. A done arriving on the same cycle the timeout would fire wins.
- STREAM:
  - Word k = seed[(k+1)*WORD_W-1 : k*WORD_W]; the least-significant word goes first.
  - out_last=1 exactly when k=NWORDS-1.
  - out_data, out_valid and out_last hold stable while out_ready=0.
  - On a handshake with k<NWORDS-1, advance k; the next word is presented in the following cycle. There are no bubbles: full throughput is one word per cycle.
  - On a handshake with k=NWORDS-1, drop out_valid and out_last and go to IDLE, so busy=0 in the next cycle.
- ERR: lasts one cycle. err=1, out_valid=0, then go to IDLE. The seed register is not updated.
- req while busy is ignored and not queued. A req held high through the return to IDLE starts a new fetch on the next posedge.
- Reset mid-operation: immediate return to IDLE with reset values on all outputs. No rng_start is issued.
- Latency: req posedge to rng_start high is 1 cycle. Done-sampling posedge to first out_valid is 1 cycle.

Test Plan:
1. Normal fetch: pulse req; the model raises rng_done 5 cycles after rng_start with zeta = 0x1F1E...0100 (byte i = i), out_ready=1 -> rng_start high for exactly one cycle. Words are 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110, 0x1F1E1D1C1B1A1918 on 4 consecutive cycles. out_last is high only on the 4th word, then busy=0.
2. Backpressure: same seed; out_ready low for 3 cycles on word 1, and low every other cycle thereafter -> each word is held stable until accepted. Exactly 4 handshakes occur, in order.
3. Timeout: rng_done never asserted -> err is a one-cycle pulse after exactly TIMEOUT (100) WAIT cycles. out_valid stays 0 throughout, then busy=0. A new req then completes normally.
4. Boundary done: rng_done first rises on WAIT cycle TIMEOUT-1 -> no err; the seed is streamed normally.
5. Ignored inputs: pulse req during STREAM, and raise rng_done in IDLE -> no second rng_start and no state change; the stream is unaffected.
6. Async reset: assert rst for 3 ns mid-STREAM, after word 1 -> all outputs read 0 immediately, with no clock edge needed. After release, the next req issues rng_start and streams the new seed starting at word 0.
